// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the MEM-stage data memory access unit: funct3 codes,
// FSM state encoding, byte-enable constants and lane helpers.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Access size is funct3[1:0] for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   return BE_BYTE0 << offset;
      2'b01:   return offset[1] ? BE_HALF_HI : BE_HALF_LO;
      2'b10:   return BE_WORD;
      default: return BE_NONE;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b01:   return offset[0];
      2'b10:   return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
module load_align_extend
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = '0;
    lane_half = '0;
    load_word = '0;
    case (byte_offset)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = byte_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_LB:   load_word = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_word = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_word = mem_rdata;
      F3_LBU:  load_word = {24'h0, lane_byte};
      F3_LHU:  load_word = {16'h0, lane_half};
      default: load_word = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage responder: turns decoded load/store commands into one request/ack
// transaction on the word-wide data memory port and stalls the pipeline meanwhile.
module data_mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  mem_state_t  state, next_state;
  logic        wr_en, rd_en, cmd_valid, cmd_illegal, cmd_ok;
  logic [2:0]  cmd_funct3;
  logic [1:0]  cmd_size;
  logic [31:0] store_data;
  logic [31:0] timeout_count;
  logic        timed_out;
  logic        start_access, fault_now;
  logic [2:0]  load_funct3;
  logic [1:0]  lane_offset;
  logic [31:0] load_word;

  // A store takes priority when both enables arrive together.
  assign wr_en      = mem_write[2];
  assign rd_en      = mem_read[3] & ~wr_en;
  assign cmd_valid  = rd_en | wr_en;
  assign cmd_funct3 = wr_en ? {1'b0, mem_write[1:0]} : mem_read[2:0];
  assign cmd_size   = cmd_funct3[1:0];
  assign cmd_illegal = (cmd_size == 2'b11) | (rd_en & cmd_funct3[2] & cmd_funct3[1]);
  assign cmd_ok     = ~cmd_illegal & ~is_misaligned(cmd_size, address[1:0]);
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LAST);

  always_comb begin
    case (cmd_size)
      2'b00:   store_data = {4{write_data[7:0]}};
      2'b01:   store_data = {2{write_data[15:0]}};
      default: store_data = write_data;
    endcase
  end

  load_align_extend u_load_align_extend (
    .funct3      (load_funct3),
    .byte_offset (lane_offset),
    .mem_rdata   (mem_rdata),
    .load_word   (load_word)
  );

  always_comb begin
    next_state   = state;
    start_access = 1'b0;
    fault_now    = 1'b0;
    busywait     = 1'b0;
    case (state)
      ST_IDLE: begin
        busywait = cmd_valid;
        if (cmd_valid) begin
          next_state = ST_COMPLETE;
          if (cmd_ok) begin
            next_state   = ST_ACCESS;
            start_access = 1'b1;
          end else begin
            fault_now = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        busywait = 1'b1;
        if (mem_ack) begin
          next_state = ST_COMPLETE;
        end else if (timed_out) begin
          next_state = ST_COMPLETE;
          fault_now  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request fields are written only when a transaction starts, so they stay
  // stable for the whole ACCESS phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_byte_en   <= '0;
      read_data     <= '0;
      access_fault  <= 1'b0;
      timeout_count <= '0;
      load_funct3   <= '0;
      lane_offset   <= '0;
    end else begin
      state        <= next_state;
      access_fault <= fault_now;
      if (start_access) begin
        mem_req       <= 1'b1;
        mem_we        <= wr_en;
        mem_addr      <= address[31:2];
        mem_wdata     <= store_data;
        mem_byte_en   <= byte_enable(cmd_size, address[1:0]);
        load_funct3   <= cmd_funct3;
        lane_offset   <= address[1:0];
        timeout_count <= '0;
      end else if (state == ST_ACCESS) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (!mem_we) read_data <= load_word;
        end else if (timed_out) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end else begin
          timeout_count <= timeout_count + 32'd1;
        end
      end
      if (fault_now) read_data <= '0;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed self-checking bench for data_mem_access_unit (timeout set to 4 cycles).
module tb_data_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        access_fault;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int compared = 0;
  int mismatched = 0;

  data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .busywait     (busywait),
    .access_fault (access_fault),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_byte_en  (mem_byte_en),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change at the falling edge; outputs are sampled #1 later, far from the rising edge.
  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 4'b0;
    mem_write = 3'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_inputs();
    address = 32'h0; write_data = 32'h0; mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
    compared++; if (busywait !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busywait: got %b want 0", busywait); end
    compared++; if (read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_read_data: got %h want 0", read_data); end
    compared++; if (access_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault: got %b want 0", access_fault); end
    compared++; if ({mem_we, mem_addr, mem_wdata, mem_byte_en} !== 67'h0) begin mismatched++; $display("[TB] FAIL reset_port: got %b %h %h %b want zeros", mem_we, mem_addr, mem_wdata, mem_byte_en); end
    RESET = 1'b0;
    next_cycle();
  endtask

  task automatic test_store_word();
    mem_write = 3'b110; address = 32'h0000_0104; write_data = 32'hDEADBEEF;
    #1;
    compared++; if (busywait !== 1'b1) begin mismatched++; $display("[TB] FAIL sw_busy_c0: got %b want 1", busywait); end
    next_cycle();
    compared++; if (busywait !== 1'b1) begin mismatched++; $display("[TB] FAIL sw_busy_c1: got %b want 1", busywait); end
    compared++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL sw_req_we: got %b%b want 11", mem_req, mem_we); end
    compared++; if (mem_addr !== 30'h41) begin mismatched++; $display("[TB] FAIL sw_addr: got %h want 41", mem_addr); end
    compared++; if (mem_byte_en !== 4'b1111) begin mismatched++; $display("[TB] FAIL sw_be: got %b want 1111", mem_byte_en); end
    compared++; if (mem_wdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    compared++; if (busywait !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_busy_c2: got %b want 0", busywait); end
    compared++; if (access_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_fault: got %b want 0", access_fault); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_req_drop: got %b want 0", mem_req); end
    idle_inputs();
    next_cycle();
    compared++; if (busywait !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_busy_after: got %b want 0", busywait); end
  endtask

  task automatic test_store_byte();
    mem_write = 3'b100; address = 32'h0000_0103; write_data = 32'h0000_00A5;
    next_cycle();
    compared++; if (mem_wdata !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); end
    compared++; if (mem_byte_en !== 4'b1000) begin mismatched++; $display("[TB] FAIL sb_be: got %b want 1000", mem_byte_en); end
    compared++; if (mem_addr !== 30'h40) begin mismatched++; $display("[TB] FAIL sb_addr: got %h want 40", mem_addr); end
    mem_ack = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_load_extend();
    // Signed then unsigned byte load of lane 2 (0x80).
    mem_read = 4'b1000; address = 32'h0000_0102; mem_rdata = 32'h1280FF34;
    next_cycle();
    compared++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_req_we: got %b%b want 10", mem_req, mem_we); end
    compared++; if (mem_byte_en !== 4'b0100) begin mismatched++; $display("[TB] FAIL lb_be: got %b want 0100", mem_byte_en); end
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    compared++; if (read_data !== 32'hFFFFFF80) begin mismatched++; $display("[TB] FAIL lb_data: got %h want ffffff80", read_data); end
    idle_inputs();
    next_cycle();
    mem_read = 4'b1100;
    next_cycle();
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    compared++; if (read_data !== 32'h00000080) begin mismatched++; $display("[TB] FAIL lbu_data: got %h want 00000080", read_data); end
    idle_inputs();
    next_cycle();
    // LH of the upper half sign-extends 0x1280 as positive.
    mem_read = 4'b1001; address = 32'h0000_0102;
    next_cycle();
    compared++; if (mem_byte_en !== 4'b1100) begin mismatched++; $display("[TB] FAIL lh_be: got %b want 1100", mem_byte_en); end
    mem_ack = 1'b1;
    next_cycle();
    compared++; if (read_data !== 32'h00001280) begin mismatched++; $display("[TB] FAIL lh_data: got %h want 00001280", read_data); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    mem_read = 4'b1010; address = 32'h0000_0200; mem_rdata = 32'hCAFEF00D;
    next_cycle();
    next_cycle();
    next_cycle();
    compared++; if (mem_req !== 1'b1 || busywait !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_wait: got req %b busy %b want 1 1", mem_req, busywait); end
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    compared++; if (read_data !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL b2b_lw_data: got %h want cafef00d", read_data); end
    compared++; if (busywait !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_complete_busy: got %b want 0", busywait); end
    mem_read = 4'b0; mem_write = 3'b101; address = 32'h0000_0202; write_data = 32'h0000_1234;
    next_cycle();
    compared++; if (busywait !== 1'b1 || mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle: got busy %b req %b want 1 0", busywait, mem_req); end
    next_cycle();
    compared++; if (mem_req !== 1'b1 || mem_byte_en !== 4'b1100) begin mismatched++; $display("[TB] FAIL b2b_sh_req: got req %b be %b want 1 1100", mem_req, mem_byte_en); end
    compared++; if (mem_wdata !== 32'h12341234 || mem_addr !== 30'h80) begin mismatched++; $display("[TB] FAIL b2b_sh_port: got %h %h want 12341234 80", mem_wdata, mem_addr); end
    mem_ack = 1'b1;
    next_cycle();
    compared++; if (read_data !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL b2b_hold: got %h want cafef00d", read_data); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    mem_read = 4'b1010; address = 32'h0000_0300;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL to_req_c%0d: got %b want 1", c, mem_req); end
    end
    next_cycle();
    compared++; if (mem_req !== 1'b0 || access_fault !== 1'b1) begin mismatched++; $display("[TB] FAIL to_complete: got req %b fault %b want 0 1", mem_req, access_fault); end
    compared++; if (read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL to_data: got %h want 0", read_data); end
    idle_inputs();
    next_cycle();
    compared++; if (access_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL to_fault_pulse: got %b want 0", access_fault); end
  endtask

  task automatic test_misaligned();
    mem_read = 4'b1100; address = 32'h0000_0103; mem_rdata = 32'h000000FF;
    next_cycle();
    mem_ack = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    mem_read = 4'b1001; address = 32'h0000_0101;
    #1;
    compared++; if (busywait !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_busy_c0: got %b want 1", busywait); end
    next_cycle();
    compared++; if (mem_req !== 1'b0 || busywait !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_no_req: got req %b busy %b want 0 0", mem_req, busywait); end
    compared++; if (access_fault !== 1'b1 || read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL mis_fault: got fault %b data %h want 1 0", access_fault, read_data); end
    idle_inputs();
    next_cycle();
    mem_write = 3'b110; address = 32'h0000_0106;
    next_cycle();
    compared++; if (mem_req !== 1'b0 || access_fault !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_sw: got req %b fault %b want 0 1", mem_req, access_fault); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_illegal();
    mem_read = 4'b1011; address = 32'h0000_0100;
    next_cycle();
    compared++; if (mem_req !== 1'b0 || access_fault !== 1'b1) begin mismatched++; $display("[TB] FAIL ill_load: got req %b fault %b want 0 1", mem_req, access_fault); end
    idle_inputs();
    next_cycle();
    mem_read = 4'b1110;
    next_cycle();
    compared++; if (mem_req !== 1'b0 || access_fault !== 1'b1) begin mismatched++; $display("[TB] FAIL ill_load110: got req %b fault %b want 0 1", mem_req, access_fault); end
    idle_inputs();
    next_cycle();
    mem_write = 3'b111;
    next_cycle();
    compared++; if (mem_req !== 1'b0 || access_fault !== 1'b1) begin mismatched++; $display("[TB] FAIL ill_store: got req %b fault %b want 0 1", mem_req, access_fault); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_store_wins();
    mem_read = 4'b1010; mem_write = 3'b110; address = 32'h0000_0104; write_data = 32'h01234567;
    next_cycle();
    compared++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL both_we: got req %b we %b want 1 1", mem_req, mem_we); end
    mem_ack = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    mem_read = 4'b1010; address = 32'h0000_0300; mem_rdata = 32'h55AA55AA;
    next_cycle();
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_pre_req: got %b want 1", mem_req); end
    RESET = 1'b1;
    next_cycle();
    compared++; if (mem_req !== 1'b0 || read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mid: got req %b data %h want 0 0", mem_req, read_data); end
    RESET = 1'b0;
    idle_inputs();
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    next_cycle();
    compared++; if (read_data !== 32'h0 || busywait !== 1'b0 || mem_req !== 1'b0 || access_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_stray_ack: got data %h busy %b req %b fault %b want 0 0 0 0", read_data, busywait, mem_req, access_fault); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_extend();
    test_back_to_back();
    test_timeout();
    test_misaligned();
    test_illegal();
    test_store_wins();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
